// File: rtl/bcd_count_ctrl.sv
// Run controller for the two-digit BCD counter: turns start/stop/clear buttons
// into count/clear/load strobes, paced by a prescaler and halted at a terminal value.
module bcd_count_ctrl #(
    parameter int unsigned PRESCALE = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       dir_up,
    input  logic [7:0] limit,
    input  logic [7:0] count_val,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic       cnt_load,
    output logic [7:0] load_val,
    output logic [1:0] state,
    output logic       done
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          start_prev_q, stop_prev_q, clear_prev_q;
    logic          en_q, en_d;
    logic          clr_q, clr_d;
    logic          load_q, load_d;
    logic          up_q, up_d;
    logic [7:0]    lval_q, lval_d;
    logic          done_q, done_d;

    logic start_ev, stop_ev, clear_ev;
    logic tick, terminal;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign start_ev = btn_start & ~start_prev_q;
    assign stop_ev  = btn_stop  & ~stop_prev_q;
    assign clear_ev = btn_clear & ~clear_prev_q;

    assign tick     = (presc_q == PS_LAST);
    assign terminal = up_q ? (count_val == lval_q) : (count_val == 8'h00);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        up_d    = up_q;
        lval_d  = lval_q;
        done_d  = done_q;

        if (clear_ev) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            presc_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        up_d    = dir_up;
                        lval_d  = {clamp_digit(limit[7:4]), clamp_digit(limit[3:0])};
                        presc_d = '0;
                        load_d  = ~dir_up;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // A stop freezes the prescaler, even on the cycle a tick was due.
                    if (stop_ev) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (terminal) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            en_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start_ev) begin
                        state_d = RUN;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
            load_q       <= 1'b0;
            up_q         <= 1'b1;
            lval_q       <= 8'h99;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            start_prev_q <= btn_start;
            stop_prev_q  <= btn_stop;
            clear_prev_q <= btn_clear;
            en_q         <= en_d;
            clr_q        <= clr_d;
            load_q       <= load_d;
            up_q         <= up_d;
            lval_q       <= lval_d;
            done_q       <= done_d;
        end
    end

    assign cnt_en   = en_q;
    assign cnt_up   = up_q;
    assign cnt_clr  = clr_q;
    assign cnt_load = load_q;
    assign load_val = lval_q;
    assign state    = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl: a cycle-level reference model predicts every
// output snapshot, a monitor compares them, and a BCD counter plant closes the loop.
module tb_bcd_count_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start, btn_stop, btn_clear;
    logic       dir_up;
    logic [7:0] limit;
    logic [7:0] count_val;
    logic       cnt_en, cnt_up, cnt_clr, cnt_load;
    logic [7:0] load_val;
    logic [1:0] state;
    logic       done;

    bcd_count_ctrl #(.PRESCALE(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_start(btn_start),
        .btn_stop (btn_stop),
        .btn_clear(btn_clear),
        .dir_up   (dir_up),
        .limit    (limit),
        .count_val(count_val),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .cnt_clr  (cnt_clr),
        .cnt_load (cnt_load),
        .load_val (load_val),
        .state    (state),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Counter plant: value kept as an integer 0..99, presented as two BCD digits.
    int pv = 0;
    always @(posedge clk) begin
        if (!rst_n)        pv <= 0;
        else if (cnt_clr)  pv <= 0;
        else if (cnt_load) pv <= int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
        else if (cnt_en)   pv <= cnt_up ? (pv + 1) % 100 : (pv + 99) % 100;
    end
    assign count_val = {4'(pv / 10), 4'(pv % 10)};

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       up;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE; run_edges counts RUN cycles since start.
    int         m_state = 0;
    int         m_run   = 0;
    bit         m_up    = 1'b1;
    int         m_lim   = 99;
    bit         mp_s = 1'b1, mp_p = 1'b1, mp_c = 1'b1;

    function automatic int min9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_step();
        exp_t e;
        bit es, ep, ec, en, clr, ld;
        int cur;
        es = btn_start && !mp_s;
        ep = btn_stop  && !mp_p;
        ec = btn_clear && !mp_c;
        en = 0; clr = 0; ld = 0;
        cur = int'(count_val[7:4]) * 10 + int'(count_val[3:0]);
        if (!rst_n) begin
            m_state = 0; m_run = 0; m_up = 1'b1; m_lim = 99;
            mp_s = 1'b1; mp_p = 1'b1; mp_c = 1'b1;
        end else begin
            mp_s = btn_start; mp_p = btn_stop; mp_c = btn_clear;
            if (ec) begin
                m_state = 0; m_run = 0; clr = 1;
            end else if (m_state == 0) begin
                if (es) begin
                    m_up    = dir_up;
                    m_lim   = min9(int'(limit) / 16) * 10 + min9(int'(limit) % 16);
                    m_run   = 0;
                    m_state = 1;
                    ld      = !dir_up;
                end
            end else if (m_state == 1) begin
                if (ep) m_state = 2;
                else begin
                    m_run++;
                    if (m_run % P == 0) begin
                        if (m_up ? (cur == m_lim) : (cur == 0)) m_state = 3;
                        else en = 1;
                    end
                end
            end else if (m_state == 2) begin
                if (es) m_state = 1;
            end
        end
        e.st  = 2'(m_state);
        e.en  = en;
        e.up  = m_up;
        e.clr = clr;
        e.ld  = ld;
        e.lv  = {4'(m_lim / 10), 4'(m_lim % 10)};
        e.dn  = (m_state == 3);
        q.push_back(e);
    endtask

    task automatic step(input bit s, input bit p, input bit c);
        btn_start = s; btn_stop = p; btn_clear = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Monitor: one expected snapshot per clock edge, compared on the falling edge.
    int   ncyc = 0;
    exp_t me, ma;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                ma = {state, cnt_en, cnt_up, cnt_clr, cnt_load, load_val, done};
                total++;
                if (ma !== me) begin
                    bad++;
                    $display("FAIL cycle%0d outputs: got st=%0d en=%0b up=%0b clr=%0b ld=%0b lv=%h dn=%0b, expected st=%0d en=%0b up=%0b clr=%0b ld=%0b lv=%h dn=%0b",
                             ncyc, ma.st, ma.en, ma.up, ma.clr, ma.ld, ma.lv, ma.dn,
                             me.st, me.en, me.up, me.clr, me.ld, me.lv, me.dn);
                end
                ncyc++;
            end
        end
    end

    initial begin
        int r;
        rst_n = 1'b0; dir_up = 1'b1; limit = 8'h05;
        btn_start = 1'b1; btn_stop = 1'b0; btn_clear = 1'b0;

        // start held through reset: no event until released and pressed again
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        rst_n = 1'b1;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        idle(2);
        step(1, 0, 0); idle(6); step(0, 0, 1); idle(2);

        // up mode to 03
        dir_up = 1'b1; limit = 8'h03;
        step(1, 0, 0); idle(20); step(0, 0, 1); idle(2);

        // down mode from 12
        dir_up = 1'b0; limit = 8'h12;
        step(1, 0, 0); idle(13 * P + 4); step(0, 0, 1); idle(2);

        // stop with prescaler at 2, resume after 10 cycles
        dir_up = 1'b1; limit = 8'h99;
        step(1, 0, 0); idle(2); step(0, 1, 0); idle(10); step(1, 0, 0); idle(6);
        step(0, 0, 1); idle(2);

        // clear, stop and start together in RUN
        step(1, 0, 0); idle(5); step(1, 1, 1); idle(3);

        // out-of-range limit clamps to 99
        dir_up = 1'b1; limit = 8'hAF;
        step(1, 0, 0); idle(100 * P + 10); step(0, 0, 1); idle(2);

        // stop coinciding with a tick, then reset mid-run with start held
        limit = 8'h50;
        step(1, 0, 0); idle(P - 1); step(0, 1, 0); idle(3); step(1, 0, 0); idle(4);
        rst_n = 1'b0; step(1, 0, 0);
        rst_n = 1'b1; step(1, 0, 0); idle(3);
        step(1, 0, 0); idle(3); step(0, 0, 1); idle(2);

        // randomized single-button traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 199));
            dir_up = 1'($urandom_range(0, 1));
            limit  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            rst_n  = (r != 199);
            if (r < 6)        step(1, 0, 0);
            else if (r < 9)   step(0, 1, 0);
            else if (r == 9)  step(0, 0, 1);
            else              step(0, 0, 0);
        end
        rst_n = 1'b1;
        idle(2);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
